// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential one-bit-per-cycle shifter.
// Op code is {op2, op1}; counts saturate at MAX_SHIFT so a 6-bit counter never wraps.
package seq_shifter_pkg;

  localparam int MAX_SHIFT = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    SHLL    = 2'b00,
    SHRL    = 2'b01,
    SHRA    = 2'b10,
    INVALID = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] sat_count(input logic [31:0] amt);
    if (amt >= 32'(MAX_SHIFT)) return CNT_W'(MAX_SHIFT);
    return amt[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step: left, logical right or arithmetic right.
// Zero latency, no flow control; invalid op yields zero.
module shift_step
  import seq_shifter_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = '0;
    case (op)
      SHLL:    dout = {din[30:0], 1'b0};
      SHRL:    dout = {1'b0, din[31:1]};
      SHRA:    dout = {din[31], din[31:1]};
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: one bit per cycle, done at T+N+1 (T+1 for N=0 or invalid op).
// start is ignored while busy; res holds from done until the next result is produced.
module seq_shifter
  import seq_shifter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] shiftamt,
  input  logic        op1,
  input  logic        op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] count;
  logic [31:0]      work;
  logic [31:0]      step_out;
  op_t              op_in;
  logic [CNT_W-1:0] n_in;

  assign op_in = op_t'({op2, op1});
  assign n_in  = sat_count(shiftamt);

  shift_step u_step (
    .op   (op_q),
    .din  (work),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= SHLL;
      count <= '0;
      work  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            work  <= (op_in == INVALID) ? 32'h0 : a;
            count <= n_in;
            busy  <= 1'b1;
            // Nothing to shift: publish the (possibly zeroed) operand next cycle.
            if (op_in == INVALID || n_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
              res   <= (op_in == INVALID) ? 32'h0 : a;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= step_out;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            res   <= step_out;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed table, busy/reset corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] shiftamt = '0;
  logic        op1 = 1'b0;
  logic        op2 = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shifter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .shiftamt (shiftamt),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .res      (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op1;
    logic        op2;
    logic [31:0] a;
    logic [31:0] sh;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the op rules: plain shift operators, counts saturated at 32.
  function automatic logic [31:0] model_res(input logic o1, input logic o2,
                                            input logic [31:0] av, input logic [31:0] sh);
    int n;
    n = (sh >= 32) ? 32 : int'(sh);
    if (o1 && o2) return 32'h0;
    if (!o1 && !o2) return (n >= 32) ? 32'h0 : (av << n);
    if (o1) return (n >= 32) ? 32'h0 : (av >> n);
    return (n >= 32) ? {32{av[31]}} : 32'($signed(av) >>> n);
  endfunction

  function automatic int model_lat(input logic o1, input logic o2, input logic [31:0] sh);
    int n;
    n = (sh >= 32) ? 32 : int'(sh);
    return ((o1 && o2) || n == 0) ? 1 : n + 1;
  endfunction

  // Entered just after a rising edge (start of cycle T); leaves just after the edge
  // that ends the done cycle, so a following call issues in the cycle after done.
  task automatic run_check(input string nm, input logic o1, input logic o2,
                           input logic [31:0] av, input logic [31:0] sh,
                           input logic [31:0] exp_res, input int exp_lat, input int repulse);
    int cyc;
    bit got;
    check({nm, "_busy_before"}, 32'(busy), 32'h0);
    op1 = o1; op2 = o2; a = av; shiftamt = sh; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; shiftamt = $urandom;
    cyc = 1;
    got = 1'b0;
    while (cyc <= 80 && !got) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        check({nm, "_busy_during"}, 32'(busy), 32'h1);
        tick();
        cyc++;
        if (cyc == repulse) begin
          start = 1'b1; op1 = 1'b1; op2 = 1'b1; a = 32'hFFFF0000; shiftamt = 32'd1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 80 cycles, expected latency %0d", nm, exp_lat);
    end else begin
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, "_res"}, res, exp_res);
      check({nm, "_busy_at_done"}, 32'(busy), 32'h1);
      tick();
      check({nm, "_done_pulse"}, 32'(done), 32'h0);
      check({nm, "_res_hold"}, res, exp_res);
    end
  endtask

  initial begin
    bit saw_done;

    vecs[0] = '{1'b0, 1'b0, 32'h00000001, 32'd4,          32'h00000010, 5};
    vecs[1] = '{1'b0, 1'b1, 32'h80000000, 32'd31,         32'hFFFFFFFF, 32};
    vecs[2] = '{1'b1, 1'b0, 32'h80000000, 32'd31,         32'h00000001, 32};
    vecs[3] = '{1'b1, 1'b0, 32'h80000000, 32'd40,         32'h00000000, 33};
    vecs[4] = '{1'b0, 1'b1, 32'h80000000, 32'd40,         32'hFFFFFFFF, 33};
    vecs[5] = '{1'b0, 1'b0, 32'h12345678, 32'd0,          32'h12345678, 1};
    vecs[6] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'd5,          32'h00000000, 1};
    vecs[7] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF,   32'h00000000, 33};
    vecs[8] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd32,         32'h00000000, 33};
    vecs[9] = '{1'b1, 1'b0, 32'hF0000000, 32'd4,          32'h0F000000, 5};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_res", res, 32'h0);

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op1, vecs[i].op2, vecs[i].a, vecs[i].sh,
                vecs[i].exp_res, vecs[i].exp_lat, 0);

    // Re-pulsed start while busy must be ignored; the next start right after done is taken.
    run_check("busy_ignore", 1'b0, 1'b0, 32'h00000001, 32'd4, 32'h00000010, 5, 2);
    run_check("after_done", 1'b1, 1'b0, 32'h00000100, 32'd8, 32'h00000001, 9, 0);

    // Reset during the third shift cycle of a 10-bit shift aborts the request.
    op1 = 1'b0; op2 = 1'b0; a = 32'h00000001; shiftamt = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_res", res, 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'h0);

    // Reset wins over a simultaneous start.
    tick();
    op1 = 1'b0; op2 = 1'b0; a = 32'h00000003; shiftamt = 32'd2; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_prio_no_done", 32'(saw_done), 32'h0);
    tick();

    for (int i = 0; i < 50; i++) begin
      logic        ro1, ro2;
      logic [31:0] ra, rsh;
      ro1 = 1'($urandom);
      ro2 = 1'($urandom);
      ra  = $urandom;
      rsh = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
      run_check($sformatf("rand%0d", i), ro1, ro2, ra, rsh,
                model_res(ro1, ro2, ra, rsh), model_lat(ro1, ro2, rsh), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
